// File: rtl/md_unit.sv
// Multiply/divide unit with HI/LO registers: multi-cycle mult/div with a Busy window,
// single-cycle mthi/mtlo. Results land in HI/LO only when the Busy window closes.
module md_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [2:0]  MDOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

  typedef enum logic {IDLE, RUN} state_t;
  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } md_op_t;

  state_t           r_state, w_next_state;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_pend_hi, r_pend_lo;
  logic             r_div0;

  logic        w_accept, w_is_mul, w_is_div, w_start_run, w_done;
  logic [63:0] w_prod;
  logic        w_a_neg, w_b_neg;
  logic [31:0] w_a_mag, w_b_mag, w_b_div, w_q_mag, w_r_mag, w_quot, w_rem;

  // Busy is high exactly when the FSM is in RUN, so an issue is accepted only from IDLE.
  assign w_accept    = Start && (r_state == IDLE);
  assign w_is_mul    = (MDOp == OP_MULT) || (MDOp == OP_MULTU);
  assign w_is_div    = (MDOp == OP_DIV)  || (MDOp == OP_DIVU);
  assign w_start_run = w_accept && (w_is_mul || w_is_div);
  assign w_done      = (r_state == RUN) && (r_cnt == CNT_W'(1));

  always_comb begin
    // NOTE: default first so every path assigns the signal and no latch is inferred.
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_start_run) w_next_state = RUN;
      RUN:     if (w_done)      w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    if (MDOp == OP_MULT)
      w_prod = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    else
      w_prod = {32'd0, A} * {32'd0, B};
  end

  // Signed division by magnitudes: quotient truncates toward zero, remainder follows
  // the dividend, and 0x80000000 / -1 wraps naturally to 0x80000000 rem 0.
  always_comb begin
    w_a_neg = (MDOp == OP_DIV) && A[31];
    w_b_neg = (MDOp == OP_DIV) && B[31];
    w_a_mag = w_a_neg ? (~A + 32'd1) : A;
    w_b_mag = w_b_neg ? (~B + 32'd1) : B;
    w_b_div = (B == 32'd0) ? 32'd1 : w_b_mag;
    w_q_mag = w_a_mag / w_b_div;
    w_r_mag = w_a_mag % w_b_div;
    w_quot  = (w_a_neg ^ w_b_neg) ? (~w_q_mag + 32'd1) : w_q_mag;
    w_rem   = w_a_neg ? (~w_r_mag + 32'd1) : w_r_mag;
  end

  always_ff @(posedge clk or negedge reset) begin
    // NOTE: non-blocking assignments for all sequential state so every flop samples pre-edge values.
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      Busy    <= 1'b0;
    end else begin
      r_state <= w_next_state;
      Busy    <= (w_next_state == RUN);
      if (w_start_run)
        r_cnt <= w_is_mul ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
      else if (r_state == RUN)
        r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  // NOTE: pending registers carry no reset; they are only consumed in RUN, which always
  // follows a load, and a reset drops the FSM to IDLE so a stale value never commits.
  always_ff @(posedge clk) begin
    if (w_start_run) begin
      r_div0 <= w_is_div && (B == 32'd0);
      if (w_is_mul) begin
        r_pend_hi <= w_prod[63:32];
        r_pend_lo <= w_prod[31:0];
      end else begin
        r_pend_hi <= w_rem;
        r_pend_lo <= w_quot;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      HI <= '0;
      LO <= '0;
    end else if (w_done) begin
      if (!r_div0) begin
        HI <= r_pend_hi;
        LO <= r_pend_lo;
      end
    end else if (w_accept && (MDOp == OP_MTHI)) begin
      HI <= A;
    end else if (w_accept && (MDOp == OP_MTLO)) begin
      LO <= A;
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: stimulus queues the expected HI/LO and Busy length of each
// multi-cycle op; a monitor measures each Busy window and compares at its close.
module tb_md_unit;

  logic        clk = 1'b0;
  logic        reset, Start;
  logic [2:0]  MDOp;
  logic [31:0] A, B;
  logic        Busy;
  logic [31:0] HI, LO;

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .Start(Start), .MDOp(MDOp),
    .A(A), .B(B), .Busy(Busy), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  localparam logic [2:0] OP_MULT = 3'd0, OP_MULTU = 3'd1, OP_DIV = 3'd2, OP_DIVU = 3'd3,
                         OP_MTHI = 3'd4, OP_MTLO = 3'd5, OP_NONE = 3'd6;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, req);
  endtask

  task automatic push(input string name, input logic [31:0] hi, input logic [31:0] lo,
                      input int cycles);
    exp_t e;
    e.name = name; e.hi = hi; e.lo = lo; e.cycles = cycles;
    exp_q.push_back(e);
  endtask

  // Operands are scrambled right after the accept edge; the result must not follow them.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    Start = 1'b1; MDOp = op; A = a; B = b;
    @(negedge clk);
    Start = 1'b0; MDOp = 3'd7; A = $urandom; B = $urandom;
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 40 && Busy; i++) @(negedge clk);
    if (Busy) check({name, "_timeout"}, {31'd0, Busy}, 32'd0);
  endtask

  // Monitor: counts Busy cycles per window and checks the committed HI/LO when it closes.
  initial begin : monitor
    int  cnt;
    bit  in_run;
    exp_t e;
    cnt = 0; in_run = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        cnt = 0; in_run = 1'b0;
      end else if (Busy) begin
        cnt++; in_run = 1'b1;
      end else if (in_run) begin
        in_run = 1'b0;
        if (exp_q.size() == 0) begin
          check("unexpected_commit", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check({e.name, "_busy_cycles"}, cnt, e.cycles);
          check({e.name, "_hi"}, HI, e.hi);
          check({e.name, "_lo"}, LO, e.lo);
        end
        cnt = 0;
      end
    end
  end

  initial begin : stimulus
    reset = 1'b0; Start = 1'b0; MDOp = 3'd7; A = '0; B = '0;
    #2;
    check("reset_busy", {31'd0, Busy}, 32'd0);
    check("reset_hi", HI, 32'd0);
    check("reset_lo", LO, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    push("mult_neg2x3", 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5);
    issue(OP_MULT, 32'hFFFF_FFFE, 32'd3);
    check("mult_busy_after_accept", {31'd0, Busy}, 32'd1);
    check("mult_hi_held_in_run", HI, 32'd0);
    check("mult_lo_held_in_run", LO, 32'd0);
    wait_idle("mult");

    push("multu_max_x2", 32'h0000_0001, 32'hFFFF_FFFE, 5);
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'd2);
    wait_idle("multu");

    push("div_neg7_2", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_idle("div");

    push("divu_by_zero", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
    issue(OP_DIVU, 32'd7, 32'd0);
    wait_idle("divu0");

    push("div_min_by_m1", 32'h0000_0000, 32'h8000_0000, 10);
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle("divmin");

    push("div_7_neg2", 32'h0000_0001, 32'hFFFF_FFFD, 10);
    issue(OP_DIV, 32'd7, 32'hFFFF_FFFE);
    wait_idle("div7");

    issue(OP_MTHI, 32'h1234_5678, 32'd0);
    check("mthi_hi", HI, 32'h1234_5678);
    check("mthi_lo_kept", LO, 32'hFFFF_FFFD);
    check("mthi_busy", {31'd0, Busy}, 32'd0);

    issue(OP_MTLO, 32'hDEAD_BEEF, 32'd0);
    check("mtlo_lo", LO, 32'hDEAD_BEEF);
    check("mtlo_hi_kept", HI, 32'h1234_5678);

    push("multu_5x6", 32'd0, 32'd30, 5);
    issue(OP_MULTU, 32'd5, 32'd6);
    Start = 1'b1; MDOp = OP_MTLO; A = 32'h1111_1111;
    @(negedge clk);
    Start = 1'b0; MDOp = 3'd7;
    check("mtlo_while_busy_ignored", LO, 32'hDEAD_BEEF);
    wait_idle("multu56");

    issue(OP_NONE, 32'hAAAA_AAAA, 32'd1);
    check("noop_hi", HI, 32'd0);
    check("noop_lo", LO, 32'd30);
    check("noop_busy", {31'd0, Busy}, 32'd0);

    push("multu_b2b_first", 32'd1, 32'd0, 5);
    issue(OP_MULTU, 32'h0001_0000, 32'h0001_0000);
    wait_idle("b2b_first");
    push("multu_b2b_second", 32'd0, 32'd15, 5);
    Start = 1'b1; MDOp = OP_MULTU; A = 32'd3; B = 32'd5;
    @(negedge clk);
    Start = 1'b0; MDOp = 3'd7; A = $urandom; B = $urandom;
    check("b2b_second_accepted", {31'd0, Busy}, 32'd1);
    wait_idle("b2b_second");

    issue(OP_DIV, 32'd100, 32'd7);
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("midrun_reset_busy", {31'd0, Busy}, 32'd0);
    check("midrun_reset_hi", HI, 32'd0);
    check("midrun_reset_lo", LO, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    push("mult_after_reset", 32'd0, 32'd12, 5);
    Start = 1'b1; MDOp = OP_MULT; A = 32'd3; B = 32'd4;
    @(negedge clk);
    Start = 1'b0; MDOp = 3'd7;
    check("accept_after_reset", {31'd0, Busy}, 32'd1);
    check("discarded_div_lo", LO, 32'd0);
    wait_idle("after_reset");

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
